// File: rtl/guitar_pkg.sv
// guitar_pkg: shared defaults and arbiter state type for the string pluck controller.
package guitar_pkg;
    localparam int DEF_NUM_STRINGS = 6;
    localparam int DEF_TICK_DIV    = 1666667;
    localparam int DEF_SUSTAIN     = 24;
    localparam int DEF_IDX_W       = 3;

    typedef enum logic {IDLE, OFFER} arb_state_e;
endpackage

// File: rtl/string_pluck_ctrl_rr_pick.sv
// rr_pick: combinational round-robin find-first over pending, starting after last grant.
module rr_pick #(
    parameter int N     = 6,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     pend_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);
    logic [IDX_W-1:0] cand;

    // Scan farthest candidate first so the nearest one after last_i wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'((int'(last_i) + k) % N);
            if (pend_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/string_pluck_ctrl.sv
// string_pluck_ctrl: shared oscillation tick, per-string sustain/oscillation,
// and round-robin arbitration of plucked strings onto one tone channel.
module string_pluck_ctrl
    import guitar_pkg::*;
#(
    parameter int NUM_STRINGS = DEF_NUM_STRINGS,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int SUSTAIN     = DEF_SUSTAIN,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_STRINGS-1:0]   pluck,
    output logic                     tick,
    output logic [NUM_STRINGS-1:0]   vibrate,
    output logic [2*NUM_STRINGS-1:0] osc_off,
    output logic                     tone_valid,
    output logic [IDX_W-1:0]         tone_idx,
    input  logic                     tone_ready
);
    localparam int CNT_W = $clog2(TICK_DIV + 1);
    localparam int SUS_W = $clog2(SUSTAIN + 1);

    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_STRINGS-1:0] pluck_q, rise, pend_q, pend_d, clr;
    logic [SUS_W-1:0]       sus_q [NUM_STRINGS];
    logic [1:0]             osc_q [NUM_STRINGS];
    arb_state_e             state_q;
    logic                   tone_valid_q, found, hs;
    logic [IDX_W-1:0]       tone_idx_q, last_q, pick;

    assign tick       = cnt_q == CNT_W'(TICK_DIV - 1);
    assign rise       = pluck & ~pluck_q;
    assign hs         = state_q == OFFER && tone_valid_q && tone_ready;
    assign tone_valid = tone_valid_q;
    assign tone_idx   = tone_idx_q;

    // A new rise on the bit being granted keeps it pending.
    always_comb begin
        clr = '0;
        clr[tone_idx_q] = hs;
        pend_d = (pend_q & ~clr) | rise;
    end

    always_comb begin
        vibrate = '0;
        osc_off = '0;
        for (int i = 0; i < NUM_STRINGS; i++) begin
            vibrate[i]       = sus_q[i] != '0;
            osc_off[2*i +: 2] = osc_q[i] & {2{sus_q[i] != '0}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            pluck_q <= '0;
            pend_q  <= '0;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
            pluck_q <= pluck;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_STRINGS; i++) begin
            if (reset) begin
                sus_q[i] <= '0;
                osc_q[i] <= '0;
            end else begin
                sus_q[i] <= rise[i] ? SUS_W'(SUSTAIN) :
                            (tick && vibrate[i]) ? sus_q[i] - SUS_W'(1) : sus_q[i];
                osc_q[i] <= !vibrate[i] ? 2'b00 : tick ? osc_q[i] ^ 2'b10 : osc_q[i];
            end
        end
    end

    rr_pick #(.N(NUM_STRINGS), .IDX_W(IDX_W)) u_pick (
        .pend_i  (pend_q),
        .last_i  (last_q),
        .idx_o   (pick),
        .found_o (found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tone_valid_q <= 1'b0;
            tone_idx_q   <= '0;
            last_q       <= IDX_W'(NUM_STRINGS - 1);
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    tone_idx_q   <= pick;
                    tone_valid_q <= 1'b1;
                    state_q      <= OFFER;
                end
                OFFER: if (tone_ready) begin
                    tone_valid_q <= 1'b0;
                    last_q       <= tone_idx_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_string_pluck_ctrl.sv
// tb_string_pluck_ctrl: directed stimulus with a grant scoreboard checked by a separate monitor.
module tb_string_pluck_ctrl;
    localparam int NS = 6;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tone_ready = 1'b0;
    logic [NS-1:0] pluck = '0;
    logic          tick, tone_valid;
    logic [NS-1:0] vibrate;
    logic [2*NS-1:0] osc_off;
    logic [IW-1:0] tone_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mcnt = 0;
    int a, b;

    typedef struct {int idx; int at;} exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    string_pluck_ctrl #(.NUM_STRINGS(NS), .TICK_DIV(4), .SUSTAIN(3), .IDX_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pluck      (pluck),
        .tick       (tick),
        .vibrate    (vibrate),
        .osc_off    (osc_off),
        .tone_valid (tone_valid),
        .tone_idx   (tone_idx),
        .tone_ready (tone_ready)
    );

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        mcnt <= reset ? 0 : (mcnt + 1) % 4;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic align(input int c);
        for (int n = 0; n < 8 && mcnt != c; n++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    always begin
        @(negedge clk);
        #1;
        chk("tick_model", tick, mcnt == 3);
        if (!reset && tone_valid && tone_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_unexpected: got idx %0d expected no grant (cycle %0d)", tone_idx, cyc + 1);
            end else begin
                mon_e = sb.pop_front();
                chk("grant_idx", tone_idx, mon_e.idx);
                chk("grant_cycle", cyc + 1, mon_e.at);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", tone_valid, 0);
        chk("rst_idx", tone_idx, 0);
        chk("rst_vib", vibrate, 0);
        chk("rst_osc", osc_off, 0);
        chk("rst_tick", tick, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1_tick", tick, (i % 4) == 2);
            chk("t1_vib", vibrate, 0);
            chk("t1_valid", tone_valid, 0);
        end

        // single held pluck on string 2
        tone_ready = 1'b1;
        align(0);
        a = cyc;
        pluck = 6'b000100;
        sb.push_back('{2, a + 3});
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            chk("t2_vib", vibrate, (j <= 11) ? 6'b000100 : 6'b0);
            chk("t2_osc", osc_off, (j >= 4 && j <= 7) ? 12'h020 : 12'h000);
            chk("t2_valid", tone_valid, j == 2);
            if (j == 20) pluck = '0;
        end
        repeat (4) @(negedge clk);
        chk("t2_drain", sb.size(), 0);

        // simultaneous plucks from a fresh round-robin pointer
        do_reset();
        a = cyc;
        pluck = 6'b101001;
        sb.push_back('{0, a + 3});
        sb.push_back('{3, a + 5});
        sb.push_back('{5, a + 7});
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 2) pluck = '0;
        end
        chk("t3_drain", sb.size(), 0);

        // stalled offer on string 4 while string 1 arrives
        tone_ready = 1'b0;
        a = cyc;
        pluck = 6'b010000;
        sb.push_back('{4, a + 12});
        sb.push_back('{1, a + 14});
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 1) chk("t4_valid0", tone_valid, 0);
            if (j >= 2 && j <= 11) begin
                chk("t4_hold_valid", tone_valid, 1);
                chk("t4_hold_idx", tone_idx, 4);
            end
            if (j == 2) pluck = 6'b010010;
            if (j == 11) tone_ready = 1'b1;
            if (j == 12) pluck = '0;
        end
        chk("t4_drain", sb.size(), 0);

        // retrigger string 0 on the tick that would expire it
        align(0);
        a = cyc;
        pluck = 6'b000001;
        sb.push_back('{0, a + 3});
        sb.push_back('{0, a + 14});
        for (int j = 1; j <= 26; j++) begin
            @(negedge clk);
            chk("t5_vib0", vibrate[0], j <= 23);
            if (j == 5) pluck = '0;
            if (j == 11) pluck = 6'b000001;
            if (j == 15) pluck = '0;
        end
        chk("t5_drain", sb.size(), 0);

        // reset in the middle of an offer
        tone_ready = 1'b0;
        pluck = 6'b101000;
        repeat (2) @(negedge clk);
        chk("t6_offer_valid", tone_valid, 1);
        chk("t6_offer_idx", tone_idx, 3);
        reset = 1'b1;
        tone_ready = 1'b1;
        pluck = '0;
        @(negedge clk);
        chk("t6_rst_valid", tone_valid, 0);
        chk("t6_rst_vib", vibrate, 0);
        chk("t6_rst_osc", osc_off, 0);
        chk("t6_rst_idx", tone_idx, 0);
        reset = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            chk("t6_idle_valid", tone_valid, 0);
        end
        b = cyc;
        pluck = 6'b111000;
        sb.push_back('{3, b + 3});
        sb.push_back('{4, b + 5});
        sb.push_back('{5, b + 7});
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 2) pluck = '0;
        end
        chk("t6_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/string_pluck_ctrl.md
# string_pluck_ctrl

Central controller for the on-screen guitar strings and the shared tone generator. It detects pluck edges on the per-string button inputs and runs one shared frame-rate tick. It drives each string's vibrate enable and oscillation offset, so individual string renderers no longer need their own dividers. It also round-robin arbitrates plucked strings onto the single tone-generator channel through a valid/ready handshake.

## Interface
- NUM_STRINGS, 6, number of strings/requesters
- TICK_DIV, 1666667, clk cycles per oscillation tick
- SUSTAIN, 24, ticks a string vibrates after a pluck
- IDX_W, 3, width of tone_idx (≥ clog2(NUM_STRINGS))

- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high
- pluck  in  NUM_STRINGS  level inputs, one per string, already synchronised
- tick  out  1  one-cycle pulse every TICK_DIV cycles
- vibrate  out  NUM_STRINGS  string i is sustaining
- osc_off  out  2*NUM_STRINGS  per-string y offset, bits [2i+1:2i], value 0 or 2
- tone_valid  out  1  tone request offered
- tone_idx  out  IDX_W  string index being offered
- tone_ready  in  1  tone generator accepts

## Operation
- Reset: all registers are cleared. tick=0, vibrate=0, osc_off=0, tone_valid=0, tone_idx=0, pending=0, FSM=IDLE, last_grant=NUM_STRINGS-1, so string 0 has first priority.
- Tick divider: cnt runs 0..TICK_DIV-1 and wraps. tick=1 during the cycle cnt==TICK_DIV-1.
- Edge detect: pluck_q is a registered copy of pluck. rise = pluck & ~pluck_q. A held button produces exactly one rise.
- Sustain counter per string, width clog2(SUSTAIN+1):
  - On rise, load SUSTAIN. This also applies when the string is already active (retrigger).
  - Else on tick with counter>0, decrement.
  - If rise and tick land in the same cycle, the load wins.
- vibrate[i] = (sustain[i] != 0).
- Oscillation per string:
  - osc register toggles bit1 on each tick while vibrate is high.
  - osc is cleared when vibrate is low.
  - osc_off = osc & {2{vibrate[i]}}.
- Pending bits:
  - rise sets pending[i].
  - An accepted handshake clears pending[tone_idx].
  - A set and a clear on the same bit in the same cycle leaves the bit set.
- Arbiter FSM:
  - IDLE: if pending≠0, pick the first set bit scanning from last_grant+1 upward with wrap. Register tone_idx, set tone_valid=1, go to OFFER.
  - OFFER: tone_valid and tone_idx are held stable until tone_ready. On valid&ready, clear the pending bit, set last_grant=tone_idx and tone_valid=0, return to IDLE.
  - A new pluck on another string during OFFER does not change tone_idx.
- Reset asserted mid-operation, including mid-OFFER, returns everything to the reset values on the next edge. No handshake completes that cycle.

## Timing
- pluck rising before edge k: pending and sustain are loaded at edge k. vibrate is high from cycle k+1.
- tone_valid rises at edge k+1 at the earliest (IDLE→OFFER).
- Handshake at edge m: tone_valid is low from m+1. Next offer is at m+2 at the earliest, giving a 1-cycle bubble. Maximum grant rate is 1 per 2 cycles.
- vibrate falls one cycle after the tick on which sustain hits 0. Total active time is between SUSTAIN-1 and SUSTAIN full tick periods plus a partial period.
- tone_ready is ignored in IDLE.

## Structure
- Shared package guitar_pkg: NUM_STRINGS, TICK_DIV, SUSTAIN defaults, and the FSM state typedef {IDLE, OFFER}.
- One sub-module, rr_pick: combinational round-robin find-first over pending, starting after last_grant. Outputs index and a found flag.
- Divider, edge detect, sustain counters and the FSM stay in the top module.

## Test plan
Bench parameters: TICK_DIV=4, SUSTAIN=3.
1. Reset held 2 cycles, then released with pluck=0 → all outputs 0; tick pulses every 4th cycle with cnt wrap.
2. Pluck string 2 held for 20 cycles, tone_ready=1 → one request only, tone_idx=2 valid for 1 cycle. vibrate[2] high for about 3 ticks. osc_off[5:4] alternates 0/2 on ticks and is 0 after vibrate falls.
3. Strings 0, 3 and 5 plucked in the same cycle, tone_ready=1 → grants in the order 0, 3, 5, each spaced 2 cycles apart.
4. tone_ready held low for 10 cycles while string 4 is offered, string 1 plucked meanwhile → tone_idx stays 4 and valid stays high. After ready, the next grant is 1.
5. Retrigger string 0 when sustain=1, coincident with a tick → sustain reloads to 3 and vibrate stays high continuously. A second pending request is raised and granted.
6. Reset asserted during OFFER → next cycle tone_valid=0, pending=0, vibrate=0. After release the first grant goes to the lowest plucked index.
